// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, mode encodings and geometry helpers for cache_ctrl
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_LOOKUP          = 3'd1,
        S_ISSUE_WAIT_BUSY = 3'd2,
        S_WAIT_DONE       = 3'd3,
        S_RESPOND         = 3'd4,
        S_ERROR           = 3'd5
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Width of the line index field of an effective address.
    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Width of the tag: whatever effective-address bits the index does not use.
    function automatic int tag_w(input int lines, input int mem_size);
        return $clog2(mem_size) - $clog2(lines);
    endfunction

endpackage

// File: rtl/cache_store.sv
// rtl/cache_store.sv - direct-mapped line store: valid vector, tag and data arrays
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears every valid bit)
//   i_rd_index     line looked up combinationally
//   o_rd_valid/o_rd_tag/o_rd_data   contents of that line
//   i_wr_en/i_wr_index/i_wr_tag/i_wr_data   write port; a write always marks the line valid
module cache_store #(
    parameter int LINES = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_index,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are ignored while the valid bit is low.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through cache controller driving a change-detect memory
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/cpu_mode/cpu_address/cpu_data   CPU request (accepted when cpu_req && cpu_ready)
//   cpu_ready                    high only in IDLE
//   cpu_done/cpu_hit             one-cycle completion pulse, hit flag valid with it
//   cpu_out                      read data, held until the next read completion
//   mem_timeout                  sticky: memory never went busy
//   mem_address/mem_data/mem_mode  registered memory request (also the last issued request)
//   mem_response/mem_out         memory busy flag and read data
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES    = 32,
    parameter int MEM_SIZE = 4096,
    parameter int WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_mode,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_data,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic        cpu_hit,
    output logic [31:0] cpu_out,
    output logic        mem_timeout,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_mode,
    input  logic        mem_response,
    input  logic [31:0] mem_out
);

    localparam int IDX_W = index_w(LINES);
    localparam int TAG_W = tag_w(LINES, MEM_SIZE);
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t r_state, w_next;

    logic             r_req_mode;
    logic [AW-1:0]    r_req_addr;
    logic [31:0]      r_req_data;
    logic [31:0]      r_mem_address;
    logic [31:0]      r_mem_data;
    logic             r_mem_mode;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_resp_data;
    logic             r_resp_hit;
    logic             r_cpu_done;
    logic             r_cpu_hit;
    logic [31:0]      r_cpu_out;
    logic             r_timeout;

    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_data;
    logic [IDX_W-1:0] w_req_index;
    logic [TAG_W-1:0] w_req_tag;
    logic [31:0]      w_req_addr_ext;
    logic             w_tag_match;
    logic             w_read_hit;
    logic             w_same;
    logic             w_wr_en;
    logic [31:0]      w_wr_data;
    logic             w_unused;

    // Bits above the memory size alias onto the same word.
    assign w_unused       = ^cpu_address[31:AW];
    assign w_req_index    = r_req_addr[IDX_W-1:0];
    assign w_req_tag      = r_req_addr[AW-1:IDX_W];
    assign w_req_addr_ext = {{(32-AW){1'b0}}, r_req_addr};

    assign w_tag_match = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_read_hit  = (r_req_mode == MODE_READ) && w_tag_match;
    // The memory only starts work when its inputs change, so an identical
    // re-issue would never raise busy; answer such requests without memory.
    assign w_same = (r_mem_address == w_req_addr_ext) && (r_mem_data == r_req_data)
                 && (r_mem_mode == r_req_mode);

    // Reads fill the line; writes only refresh a line that already holds the tag.
    assign w_wr_en   = (r_state == S_WAIT_DONE) && !mem_response
                    && ((r_req_mode == MODE_READ) || w_tag_match);
    assign w_wr_data = (r_req_mode == MODE_READ) ? mem_out : r_req_data;

    cache_store #(
        .LINES(LINES),
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_req_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_req_index),
        .i_wr_tag   (w_req_tag),
        .i_wr_data  (w_wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_read_hit || w_same) w_next = S_RESPOND;
                else                      w_next = S_ISSUE_WAIT_BUSY;
            end
            S_ISSUE_WAIT_BUSY: begin
                if (mem_response)                              w_next = S_WAIT_DONE;
                else if (r_wait_cnt == CNT_W'(WAIT_MAX - 1))   w_next = S_ERROR;
            end
            S_WAIT_DONE: begin
                if (!mem_response) w_next = S_RESPOND;
            end
            S_RESPOND: w_next = S_IDLE;
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_mode    <= MODE_READ;
            r_req_addr    <= '0;
            r_req_data    <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_mode    <= MODE_READ;
            r_wait_cnt    <= '0;
            r_resp_data   <= '0;
            r_resp_hit    <= 1'b0;
            r_cpu_done    <= 1'b0;
            r_cpu_hit     <= 1'b0;
            r_cpu_out     <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_cpu_done <= 1'b0;
            r_cpu_hit  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_req_mode <= cpu_mode;
                        r_req_addr <= cpu_address[AW-1:0];
                        r_req_data <= cpu_data;
                    end
                end
                S_LOOKUP: begin
                    r_wait_cnt <= '0;
                    r_resp_hit <= w_read_hit;
                    if (w_read_hit) begin
                        r_resp_data <= w_rd_data;
                    end else if (w_same) begin
                        // Memory still presents the result of this very request.
                        r_resp_data <= mem_out;
                    end else begin
                        r_mem_address <= w_req_addr_ext;
                        r_mem_data    <= r_req_data;
                        r_mem_mode    <= r_req_mode;
                    end
                end
                S_ISSUE_WAIT_BUSY: begin
                    if (!mem_response) begin
                        if (r_wait_cnt == CNT_W'(WAIT_MAX - 1)) r_timeout <= 1'b1;
                        else r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!mem_response) r_resp_data <= mem_out;
                end
                S_RESPOND: begin
                    r_cpu_done <= 1'b1;
                    r_cpu_hit  <= r_resp_hit;
                    if (r_req_mode == MODE_READ) r_cpu_out <= r_resp_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_ready   = (r_state == S_IDLE);
    assign cpu_done    = r_cpu_done;
    assign cpu_hit     = r_cpu_hit;
    assign cpu_out     = r_cpu_out;
    assign mem_timeout = r_timeout;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign mem_mode    = r_mem_mode;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - self-checking bench for cache_ctrl with a change-detect memory and reference model
module tb_cache_ctrl;

    localparam int LINES    = 32;
    localparam int MEM_SIZE = 4096;
    localparam int WAIT_MAX = 8;
    localparam int AW       = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_mode;
    logic [31:0] cpu_address;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_hit;
    logic [31:0] cpu_out;
    logic        mem_timeout;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_mode;
    logic        mem_response;
    logic [31:0] mem_out = 32'hAAAA0000;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_ctrl #(
        .LINES(LINES),
        .MEM_SIZE(MEM_SIZE),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_mode     (cpu_mode),
        .cpu_address  (cpu_address),
        .cpu_data     (cpu_data),
        .cpu_ready    (cpu_ready),
        .cpu_done     (cpu_done),
        .cpu_hit      (cpu_hit),
        .cpu_out      (cpu_out),
        .mem_timeout  (mem_timeout),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_mode     (mem_mode),
        .mem_response (mem_response),
        .mem_out      (mem_out)
    );

    // Change-detect memory: busy one edge after its inputs change, idle and done one edge later.
    logic [31:0] mem_arr [MEM_SIZE];
    logic [31:0] lat_a = '0;
    logic [31:0] lat_d = '0;
    logic        lat_m = 1'b0;
    logic        busy  = 1'b0;
    logic        stuck = 1'b0;
    int          busy_cnt = 0;

    assign mem_response = busy;

    always @(posedge clk) begin
        if (busy) begin
            busy <= 1'b0;
            if (lat_m) mem_arr[lat_a[AW-1:0]] = lat_d;
            else       mem_out <= mem_arr[lat_a[AW-1:0]];
        end else if (!stuck && ({mem_address, mem_data, mem_mode} != {lat_a, lat_d, lat_m})) begin
            lat_a <= mem_address;
            lat_d <= mem_data;
            lat_m <= mem_mode;
            busy  <= 1'b1;
        end
    end

    always @(posedge clk) if (mem_response) busy_cnt <= busy_cnt + 1;

    // Reference model: memory contents, line occupancy, last request sent to memory.
    logic [31:0] ref_mem [MEM_SIZE];
    bit          m_valid [LINES];
    int          m_tag   [LINES];
    int          m_last_a;
    logic [31:0] m_last_d;
    logic        m_last_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_last_a = 0;
        m_last_d = '0;
        m_last_m = 1'b0;
    endtask

    task automatic do_req(input logic mode, input logic [31:0] addr, input logic [31:0] data);
        int          eff, idx, tg, lat, b0;
        bit          hit, same, got;
        logic [31:0] exp_out;
        eff  = int'(addr[AW-1:0]);
        idx  = eff % LINES;
        tg   = eff / LINES;
        hit  = (mode == 1'b0) && m_valid[idx] && (m_tag[idx] == tg);
        same = (m_last_a == eff) && (m_last_d == data) && (m_last_m == mode);
        exp_out = ref_mem[eff];
        if (mode) ref_mem[eff] = data;
        else if (!hit && !same) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        if (!hit && !same) begin
            m_last_a = eff;
            m_last_d = data;
            m_last_m = mode;
        end

        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cpu_ready;
        end
        check("ready_wait", {31'd0, got}, 32'd1);
        cpu_req     = 1'b1;
        cpu_mode    = mode;
        cpu_address = addr;
        cpu_data    = data;
        b0          = busy_cnt;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        check("ready_low", {31'd0, cpu_ready}, 32'd0);
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (cpu_done) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, (hit || same) ? 32'd2 : 32'd5);
        check("hit", {31'd0, cpu_hit}, {31'd0, hit});
        if (!mode) check("rdata", cpu_out, exp_out);
        check("ready_done", {31'd0, cpu_ready}, 32'd1);
        check("mem_busy", {31'd0, busy_cnt != b0}, {31'd0, !(hit || same)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_done",  {31'd0, cpu_done}, 32'd0);
        check("rst_hit",   {31'd0, cpu_hit}, 32'd0);
        check("rst_out",   cpu_out, 32'd0);
        check("rst_tmo",   {31'd0, mem_timeout}, 32'd0);
        check("rst_maddr", mem_address, 32'd0);
        check("rst_mdata", mem_data, 32'd0);
        check("rst_mmode", {31'd0, mem_mode}, 32'd0);
        check("rst_ready", {31'd0, cpu_ready}, 32'd1);
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        logic [31:0] a, d;
        logic        m;
        int          tc;
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem_arr[i] = 32'hAAAA0000 | i;
            ref_mem[i] = 32'hAAAA0000 | i;
        end
        rst = 1'b1; cpu_req = 1'b0; cpu_mode = 1'b0; cpu_address = '0; cpu_data = '0;
        do_reset();

        do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b1, 32'h10, 32'h1234);
        do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b1, 32'h50, 32'h77);
        do_req(1'b0, 32'h50, 32'h0);
        do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b0, 32'h10 + LINES, 32'h0);
        do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b0, 32'h10 + MEM_SIZE, 32'h0);
        do_req(1'b0, 32'h20, 32'h0);
        do_req(1'b1, 32'h20, 32'h99);
        do_req(1'b0, 32'h20, 32'h0);
        do_req(1'b1, 32'h20, 32'h99);

        for (int n = 0; n < 150; n++) begin
            a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 5)
              | 32'($urandom_range(0, 3));
            m = 1'($urandom_range(0, 1));
            d = 32'($urandom_range(0, 2));
            do_req(m, a, d);
        end
        for (int hi = 0; hi < 4; hi++) begin
            for (int lo = 0; lo < 4; lo++) begin
                check("mem_content", mem_arr[(hi << 5) | lo], ref_mem[(hi << 5) | lo]);
            end
        end

        stuck = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_mode = 1'b0; cpu_address = 32'h123; cpu_data = 32'h5;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        tc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (mem_timeout) begin
                tc = c;
                break;
            end
        end
        check("timeout_cycle", tc, WAIT_MAX + 1);
        repeat (5) @(posedge clk);
        #1;
        check("err_ready", {31'd0, cpu_ready}, 32'd0);
        check("err_sticky", {31'd0, mem_timeout}, 32'd1);
        check("err_done", {31'd0, cpu_done}, 32'd0);
        stuck = 1'b0;
        do_reset();
        do_req(1'b0, 32'h10, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
